// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle,
// followed by a single sign-correction cycle before HI/LO are written.
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    state_t state, state_n;

    // {upper, lower} working register: product for MUL, {remainder, quotient} for DIV
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               sgn_a, sgn_b, is_div, b_zero;
    logic [CW-1:0]      cnt;

    // op codes 0..3 have op[2]==0; op[0]==0 marks the signed variants
    logic accept, mt_write, last;
    assign accept   = (state == IDLE) && op_valid && !flush && !op[2];
    assign mt_write = (state == IDLE) && op_valid && !flush && (op == 3'd4 || op == 3'd5);
    assign last     = (cnt == CW'(WIDTH - 1));

    // operand sign bits only matter for signed ops, so they are masked at accept
    logic sa_in, sb_in;
    assign sa_in = srca[WIDTH-1] & ~op[0];
    assign sb_in = srcb[WIDTH-1] & ~op[0];

    // multiply step: conditionally add multiplicand to upper half, shift right
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
    assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    // divide step: shift in next dividend bit, subtract divisor if it fits.
    // The partial remainder is always below the divisor, so WIDTH+1 bits suffice.
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   trial;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign trial    = rem_sh[WIDTH-1:0] - mag_b;
    assign div_ok   = rem_sh >= {1'b0, mag_b};
    assign div_next = div_ok ? {trial, acc[WIDTH-2:0], 1'b1}
                             : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    // sign correction; remainder follows the dividend's sign
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_fix = (sgn_a ^ sgn_b) ? -acc : acc;
    assign quo_fix  = (sgn_a ^ sgn_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = sgn_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // next-state and combinational stall request
    always_comb begin
        state_n = state;
        stall   = 1'b0;
        case (state)
            IDLE: if (accept) begin
                stall   = 1'b1;
                state_n = op[1] ? DIV : MUL;
            end
            MUL: begin
                stall   = 1'b1;
                state_n = flush ? IDLE : (last ? FIX : MUL);
            end
            DIV: begin
                stall   = 1'b1;
                state_n = flush ? IDLE : (last ? FIX : DIV);
            end
            FIX: begin
                stall   = 1'b1;
                state_n = flush ? IDLE : DONE;
            end
            DONE:    state_n = IDLE;  // op_valid ignored so the instruction is not re-issued
            default: state_n = IDLE;
        endcase
    end

    // operand latch and iteration datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            sgn_a  <= 1'b0;
            sgn_b  <= 1'b0;
            is_div <= 1'b0;
            b_zero <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            mag_a  <= sa_in ? -srca : srca;
            mag_b  <= sb_in ? -srcb : srcb;
            sgn_a  <= sa_in;
            sgn_b  <= sb_in;
            is_div <= op[1];
            b_zero <= (srcb == '0);
            cnt    <= '0;
            // MUL starts with the multiplier in the low half, DIV with the dividend
            acc    <= {{WIDTH{1'b0}}, (sb_in && !op[1]) ? -srcb :
                                      (sa_in && op[1])  ? -srca :
                                      (op[1] ? srca : srcb)};
        end else if (state == MUL) begin
            acc <= mul_next;
            cnt <= cnt + 1'b1;
        end else if (state == DIV) begin
            acc <= div_next;
            cnt <= cnt + 1'b1;
        end
    end

    // HI/LO: direct writes in IDLE, result commit at the end of FIX
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (mt_write) begin
            if (op == 3'd4) hi <= srca;
            else            lo <= srca;
        end else if (state == FIX && !flush) begin
            if (!is_div) begin
                {hi, lo} <= prod_fix;
            end else if (!b_zero) begin
                lo <= quo_fix;
                hi <= rem_fix;
            end
        end
    end

    // registered status flags derived from the upcoming state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            div0 <= 1'b0;
        end else begin
            busy <= (state_n == MUL) || (state_n == DIV) || (state_n == FIX);
            done <= (state_n == DONE);
            div0 <= (state_n == DONE) && is_div && b_zero;
        end
    end
endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo: a 32-bit instance for the main cases and
// an 8-bit instance for the signed-overflow corner.
module tb_muldiv_hilo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] srca, srcb;
    logic        stall, busy, done, div0;
    logic [31:0] hi, lo;

    logic        op_valid8;
    logic [2:0]  op8;
    logic [7:0]  srca8, srcb8;
    logic        stall8, busy8, done8, div08;
    logic [7:0]  hi8, lo8;

    int n_chk = 0;
    int n_err = 0;

    muldiv_hilo #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .srca(srca), .srcb(srcb),
        .flush(flush), .stall(stall), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    muldiv_hilo #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .op_valid(op_valid8), .op(op8), .srca(srca8), .srcb(srcb8),
        .flush(flush), .stall(stall8), .busy(busy8), .done(done8), .div0(div08), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op on the 32-bit unit and return at the first non-stall cycle
    // (sampled 1 time unit after the falling edge), reporting the stall length.
    task automatic run32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output int cyc);
        @(negedge clk);
        op_valid = 1'b1; op = o; srca = a; srcb = b;
        cyc = 0;
        #1;
        while (stall && cyc < 200) begin
            cyc++;
            @(negedge clk);
            if (!hold) begin
                op_valid = 1'b0;
                srca = 32'hDEAD_BEEF;
                srcb = 32'h0BAD_F00D;
            end
            #1;
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b0; flush = 1'b0;
        op_valid = 1'b0; op = 3'd0; srca = '0; srcb = '0;
        op_valid8 = 1'b0; op8 = 3'd0; srca8 = '0; srcb8 = '0;

        #1;
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        check("rst_busy_done_div0", {61'h0, busy, done, div0}, 64'h0);
        check("rst_stall", 64'(stall), 64'h0);
        @(negedge clk); rst = 1'b1;

        // 1: MULTU FFFFFFFF * 2
        run32(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, cyc);
        check("t1_stall_len", 64'(cyc), 64'd34);
        check("t1_done", 64'(done), 64'h1);
        check("t1_hi", 64'(hi), 64'h1);
        check("t1_lo", 64'(lo), 64'hFFFF_FFFE);
        @(negedge clk); #1;
        check("t1_done_pulse", 64'(done), 64'h0);

        // 2: MULT -3*7, DIV -7/2
        run32(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, cyc);
        check("t2_mul_len", 64'(cyc), 64'd34);
        check("t2_mul_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run32(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, cyc);
        check("t2_div_len", 64'(cyc), 64'd34);
        check("t2_div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("t2_div_hi", 64'(hi), 64'hFFFF_FFFF);

        // 3: MTHI/MTLO preload, then DIVU by zero leaves them alone
        @(negedge clk);
        op_valid = 1'b1; op = 3'd4; srca = 32'h1234_5678; #1;
        check("t3_mthi_nostall", 64'(stall), 64'h0);
        @(negedge clk);
        op = 3'd5; srca = 32'h9ABC_DEF0; #1;
        check("t3_mthi_hi", 64'(hi), 64'h1234_5678);
        @(negedge clk);
        op_valid = 1'b0; #1;
        check("t3_mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
        run32(3'd3, 32'h0000_0005, 32'h0, 1'b0, cyc);
        check("t3_len", 64'(cyc), 64'd34);
        check("t3_done_div0", {62'h0, done, div0}, 64'h3);
        check("t3_hilo_kept", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

        // 4: flush at iteration 10 aborts, then a clean DIVU 100/7
        @(negedge clk);
        op_valid = 1'b1; op = 3'd3; srca = 32'd100; srcb = 32'd7; #1;
        check("t4_accept_stall", 64'(stall), 64'h1);
        @(negedge clk); op_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1; #1;
        check("t4_flush_cycle_stall", 64'(stall), 64'h1);
        @(negedge clk); flush = 1'b0; #1;
        check("t4_after_flush_stall_busy", {62'h0, stall, busy}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            check("t4_no_done", 64'(done), 64'h0);
            @(negedge clk); #1;
        end
        check("t4_hilo_kept", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        run32(3'd3, 32'd100, 32'd7, 1'b0, cyc);
        check("t4_lo", 64'(lo), 64'hE);
        check("t4_hi", 64'(hi), 64'h2);

        // 5: op_valid held through DONE executes once; reset mid-MUL clears everything
        run32(3'd1, 32'd3, 32'd4, 1'b1, cyc);
        check("t5_len", 64'(cyc), 64'd34);
        check("t5_lo", 64'(lo), 64'hC);
        op_valid = 1'b0;
        @(negedge clk); #1;
        check("t5_no_reissue", {62'h0, stall, busy}, 64'h0);
        @(negedge clk);
        op_valid = 1'b1; op = 3'd1; srca = 32'd5; srcb = 32'd6;
        @(negedge clk); op_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0; #1;
        check("t5_rst_hilo", {hi, lo}, 64'h0);
        check("t5_rst_stall", 64'(stall), 64'h0);
        @(negedge clk); rst = 1'b1;

        // 6: 8-bit signed overflow -128 / -1
        @(negedge clk);
        op_valid8 = 1'b1; op8 = 3'd2; srca8 = 8'h80; srcb8 = 8'hFF;
        cyc = 0; #1;
        while (stall8 && cyc < 100) begin
            cyc++;
            @(negedge clk); op_valid8 = 1'b0; #1;
        end
        check("t6_len", 64'(cyc), 64'd10);
        check("t6_done", 64'(done8), 64'h1);
        check("t6_lo", 64'(lo8), 64'h80);
        check("t6_hi", 64'(hi8), 64'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers. Sits beside the ALU in the execute stage of the 5-stage MIPS pipeline.
- Raises a stall request so the hazard unit freezes F/D/E while an operation runs.
- Parametrised in operand width. Supports signed/unsigned MULT/DIV and MTHI/MTLO.
- Adds multi-cycle execution, abort-on-flush and divide-by-zero handling, none of which the single-cycle ALU path has.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
op_valid  input  1  execute stage holds a mul/div/mthi/mtlo instruction
op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, others=no-op
srca  input  WIDTH  forwarded rs operand (dividend / multiplicand / MTHI-MTLO data)
srcb  input  WIDTH  forwarded rt operand (divisor / multiplier)
flush  input  1  execute-stage flush; aborts the operation in flight
stall  output  1  combinational stall request to the hazard unit
busy  output  1  registered; high while state is MUL, DIV or FIX
done  output  1  one-cycle pulse when HI/LO have been updated by MULT/DIV
div0  output  1  one-cycle pulse with done when divisor was zero
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; hi=lo=0; busy=done=div0=0. Reset mid-operation discards the operation and leaves no partial HI/LO update.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, accepting a MULT/MULTU/DIV/DIVU (op_valid=1, flush=0):
  - Latch operand magnitudes; signed ops take the absolute value.
  - Latch both sign bits and the divisor-zero flag; clear the counter.
  - Next state: MUL or DIV.
- IDLE, MTHI/MTLO (op_valid=1, flush=0): write hi or lo at that clock edge. No stall; stay in IDLE.
- MUL: radix-2 shift-add, one bit per cycle, WIDTH cycles, 2*WIDTH-bit accumulator. Then go to FIX.
- DIV: restoring radix-2, one quotient bit per cycle, WIDTH cycles. Then go to FIX.
- FIX (1 cycle), sign correction:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - At the end of FIX, write {hi,lo}=product, or lo=quotient and hi=remainder.
  - Go to DONE.
- Divide by zero: runs the full latency, but hi and lo are NOT written. div0 pulses in DONE.
- Overflow (most-negative / -1, signed): lo=most-negative value, hi=0. Two's-complement wrap; no flag.
- DONE (1 cycle): done=1 and stall=0, so the instruction leaves E. op_valid is ignored in this cycle to prevent re-issue. Next state: IDLE.
- stall = (IDLE & op_valid & op in {0..3} & !flush) | MUL | DIV | FIX.
- Latency: stall is high for exactly WIDTH+2 consecutive cycles (accept cycle, WIDTH iterations, FIX). New hi/lo are visible from the DONE cycle.
- flush while in MUL/DIV/FIX: go to IDLE at the next edge. hi/lo are unchanged, done does not pulse, and stall stays combinational on state (high in the flush cycle, low after).
- flush in IDLE: blocks any accept or MTHI/MTLO write in that cycle.
- Operands are sampled only at the accept edge; later changes on srca/srcb are ignored.
- Unused op codes (6, 7): no effect.

Test Plan:
1. MULTU srca=FFFFFFFF, srcb=00000002 -> stall high for exactly 34 cycles; next cycle done=1, hi=00000001, lo=FFFFFFFE.
2. MULT srca=FFFFFFFD (-3), srcb=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB. Then DIV -7/2 (srca=FFFFFFF9, srcb=00000002) -> lo=FFFFFFFD, hi=FFFFFFFF.
3. Preload via MTHI 12345678 and MTLO 9ABCDEF0 (no stall, values visible the next cycle). Then DIVU srca=00000005, srcb=0 -> 34-cycle stall, div0=1 and done=1 in the same cycle, hi/lo still 12345678/9ABCDEF0.
4. Start DIVU 100/7, assert flush at iteration 10 -> IDLE next cycle, no done, hi/lo unchanged. A following DIVU 100/7 -> lo=0000000E, hi=00000002.
5. Hold op_valid=1 with MULTU 3*4 through DONE -> exactly one operation executes, lo=0000000C. Drop rst low mid-MUL -> hi=lo=0, stall=0 immediately.
6. WIDTH=8, DIV srca=80 (-128), srcb=FF (-1) -> stall 10 cycles, lo=80, hi=00.
